prio_encode_irq: RTL and testbench
==================================

// Module: prio_encode_irq
// PURPOSE
//  Parametrised, registered priority encoder with request latching and a valid/ack handshake.
//  Converts N request lines into a W-bit binary code for an interrupt / vector-select path in MCS8.
//  Generalises the 8-to-3 one-hot encoder: arbitrary N, multi-hot inputs, masking,
//  edge or level capture, and fixed or rotating priority.
// PARAMETERS
//  N       8           number of request lines (2..64)
//  W       $clog2(N)   code width
//  EDGE    1           1: capture rising edges into sticky pending bits; 0: level-sensitive
//  ROTATE  0           0: fixed priority, index 0 highest; 1: round-robin after last grant
// PORTS
//  Clk     in   1  single clock; all state updates on the rising edge
//  Rst_n   in   1  synchronous reset, active-low
//  Req     in   N  request lines; synchronous to Clk
//  Mask    in   N  1 = request blocked from arbitration (still latched as pending)
//  Ack     in   1  consumer accepts current Code; honoured only while Vld=1
//  Vld     out  1  Code holds a valid grant
//  Code    out  W  binary index of granted request
//  Pend    out  N  pending-request register (debug/status)
//  Any     out  1  registered OR of (Pend & ~Mask)
// BEHAVIOUR
//  Reset (Rst_n=0 at a rising edge): Vld=0, Code=0, Pend=0, Any=0, Req_d=0, Last=N-1, FSM=IDLE.
//   Reset overrides every other event, including Ack in the same cycle.
//   Req_d resets to 0, so in EDGE mode a Req held high through reset captures one edge afterwards.
//  Capture, EDGE=1: on each edge, Pend[i] <= (Pend[i] & ~clr[i]) | (Req[i] & ~Req_d[i]).
//   Req_d <= Req.
//   clr[i]=1 only on an accepted Ack with Code==i.
//   A new edge on bit i in the same cycle as clr[i] wins: Pend[i] stays 1.
//  Capture, EDGE=0: Pend <= Req each cycle. Ack never clears Pend; the requester must drop Req.
//  Eligible E = Pend & ~Mask. Any <= |E each cycle.
//  Selection:
//   ROTATE=0: lowest set index of E.
//   ROTATE=1: first set index of E searching Last+1, Last+2, ... modulo N (wraps N-1 -> 0).
//  FSM, two states:
//   IDLE: if E!=0, Code <= sel and Vld <= 1, go PRESENT; else stay, Vld=0.
//   PRESENT: Code and Vld held stable, independent of Req/Mask changes.
//    On Ack=1: Vld <= 0, Last <= Code, clear pending per capture rule, go IDLE.
//  Latency, EDGE=1:
//   Req first sampled high at edge t sets Pend at t.
//   IDLE samples E at t+1; Vld=1 after edge t+1.
//   One mandatory IDLE bubble after each Ack: back-to-back grants are >=2 cycles apart.
//  Ack while Vld=0 is ignored.
//  Code retains its last value while Vld=0; only meaningful when Vld=1.
//  Masking a request while it is presented does not withdraw it; the mask applies from the next IDLE.
//  All arithmetic is unsigned, W bits; modulo-N wrap is explicit (correct for non-power-of-2 N).
// STRUCTURE
//  Package mcs8_irq_pkg: FSM state typedef {IDLE, PRESENT}; clog2 helper; default N/W localparams.
//  Sub-module prio_encode (purely combinational): in [N], base [W], rot -> sel [W], hit.
//   Implements fixed search when rot=0.
//   Implements rotated search when rot=1: double-width vector shifted by base+1, then wrapped.
//  Top level: capture register, Any register, FSM, output registers.
// TESTING
//  1. Reset, then Req=8'h00 for 4 cycles -> Vld=0, Code=0, Pend=0, Any=0 throughout.
//  2. EDGE=1, ROTATE=0: pulse Req=8'h24 for 1 cycle, Ack each grant when seen
//     -> Code=2, then Code=5 (>=2 cycles after the first Ack), then Pend=0 and Vld=0.
//  3. ROTATE=1, Req held at 8'h81 with level mode (EDGE=0), Ack on every Vld
//     -> Codes alternate 0,7,0,7 (wrap from 7 to 0 verified).
//  4. Mask=8'h01, pulse Req[0] and Req[3] -> Code=3 only.
//     Then Mask=0 -> Code=0 is granted next (latched while masked).
//  5. During PRESENT with Code=4: new Req[4] edge in the same cycle as Ack -> Pend[4]=1 after that edge;
//     Code=4 is re-granted 2 cycles later.
//  6. Rst_n=0 while PRESENT and Ack=1 in the same cycle -> all outputs at reset values next cycle;
//     Req held high through reset yields one new grant afterwards.

Source files
------------

// File: rtl/mcs8_irq_pkg.sv
// ----------------------------------------------------------------------------
// mcs8_irq_pkg
//   Shared definitions for the MCS8 interrupt / vector-select priority encoder.
//   Holds the arbitration FSM state type, default sizing localparams and a
//   ceiling-log2 helper usable in parameter defaults.
// ----------------------------------------------------------------------------
package mcs8_irq_pkg;

    // Arbitration FSM: IDLE searches for an eligible request, PRESENT holds
    // a grant stable until the consumer acknowledges it.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_t;

    // Default geometry matches the original 8-to-3 encoder.
    localparam int DEFAULT_N = 8;
    localparam int DEFAULT_W = 3;

    // Ceiling log2, never smaller than 1 so a code port always exists.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prio_encode.sv
// ----------------------------------------------------------------------------
// prio_encode
//   Purely combinational priority search over an N-bit request vector.
//
//   Ports
//     in    [N]  candidate vector (bit i set = index i may be selected)
//     base  [W]  index of the previous grant, used only when rot=1
//     rot   1    0: lowest set index wins; 1: first set index after base,
//                   wrapping from N-1 back to 0
//     sel   [W]  selected index (meaningful only when hit=1)
//     hit   1    at least one bit of in is set
// ----------------------------------------------------------------------------
module prio_encode
    import mcs8_irq_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] in,
    input  logic [W-1:0] base,
    input  logic         rot,
    output logic [W-1:0] sel,
    output logic         hit
);

    logic [W-1:0] start;
    logic [N-1:0] window;
    logic [W-1:0] offset;
    logic         found;
    logic [W:0]   sum;

    // Rotated search: concatenating the vector with itself and shifting
    // right by base+1 puts index base+1 at bit 0, with the wrapped indices
    // following it in order. A fixed lowest-bit search on that window then
    // gives an offset relative to start, which is mapped back modulo N.
    // The wrap of start and of the final sum is explicit so that
    // non-power-of-two N behaves correctly.
    always_comb begin
        start  = (base == W'(N - 1)) ? '0 : base + W'(1);
        window = rot ? N'({in, in} >> start) : in;

        offset = '0;
        found  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (window[i]) begin
                offset = W'(i);
                found  = 1'b1;
            end
        end

        if (rot) begin
            sum = {1'b0, start} + {1'b0, offset};
        end else begin
            sum = {1'b0, offset};
        end
        if (sum >= (W + 1)'(N)) begin
            sum = sum - (W + 1)'(N);
        end

        sel = sum[W-1:0];
        hit = found;
    end

endmodule

// File: rtl/prio_encode_irq.sv
// ----------------------------------------------------------------------------
// prio_encode_irq
//   Registered priority encoder with request latching and a valid/ack
//   handshake, feeding the MCS8 interrupt / vector-select path.
//
//   Parameters
//     N       number of request lines (2..64)
//     W       code width
//     EDGE    1: rising edges of req are captured into sticky pending bits
//             0: pending simply follows req (level-sensitive)
//     ROTATE  0: fixed priority, index 0 highest
//             1: round-robin starting after the last accepted grant
//
//   Ports
//     clk    rising-edge clock for all state
//     rst_n  synchronous reset, active-low
//     req    [N] request lines, synchronous to clk
//     mask   [N] 1 = request blocked from arbitration (still latched)
//     ack    consumer accepts the current code; ignored while vld=0
//     vld    code holds a valid grant
//     code   [W] binary index of the granted request
//     pend   [N] pending-request register (status)
//     any    registered OR of the unmasked pending requests
// ----------------------------------------------------------------------------
module prio_encode_irq
    import mcs8_irq_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int W      = clog2(N),
    parameter int EDGE   = 1,
    parameter int ROTATE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic         vld,
    output logic [W-1:0] code,
    output logic [N-1:0] pend,
    output logic         any
);

    irq_state_t   state;
    logic [N-1:0] req_d;
    logic [W-1:0] last;

    logic [N-1:0] eligible;
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic         accept;
    logic [W-1:0] sel;
    logic         hit;

    assign eligible = pend & ~mask;
    assign rise     = req & ~req_d;

    // vld is high exactly while PRESENT, so an ack only counts in that state.
    assign accept   = (state == PRESENT) && ack;

    // Only the currently presented index is cleared on an accepted ack.
    assign clr      = accept ? (N'(1) << code) : '0;

    prio_encode #(
        .N (N),
        .W (W)
    ) u_select (
        .in   (eligible),
        .base (last),
        .rot  (ROTATE != 0),
        .sel  (sel),
        .hit  (hit)
    );

    // Request capture. In edge mode the new-edge term is OR-ed after the
    // clear, so a fresh edge arriving together with the ack that retires the
    // same index keeps it pending. req_d resets to zero, so a request held
    // high through reset is seen as one new edge once reset is released.
    // In level mode ack never clears anything; the requester drops req.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend  <= '0;
            req_d <= '0;
        end else begin
            req_d <= req;
            if (EDGE != 0) begin
                pend <= (pend & ~clr) | rise;
            end else begin
                pend <= req;
            end
        end
    end

    // Status flag: any unmasked pending request, one register stage behind
    // the pending bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any <= 1'b0;
        end else begin
            any <= |eligible;
        end
    end

    // Grant FSM. A grant is taken from the eligible set only in IDLE, so
    // mask or req changes while PRESENT never disturb the presented code.
    // Returning to IDLE on every ack forces one idle cycle between grants.
    // code keeps its old value after the ack; only vld drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            vld   <= 1'b0;
            code  <= '0;
            last  <= W'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        code  <= sel;
                        vld   <= 1'b1;
                        state <= PRESENT;
                    end else begin
                        vld <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        vld   <= 1'b0;
                        last  <= code;
                        state <= IDLE;
                    end
                end
                default: begin
                    vld   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_encode_irq.sv
// ----------------------------------------------------------------------------
// tb_prio_encode_irq
//   Self-checking bench for prio_encode_irq. Three instances share req, mask
//   and rst_n, each with its own ack:
//     inst 0: EDGE=1 ROTATE=0    inst 1: EDGE=0 ROTATE=1    inst 2: EDGE=1 ROTATE=1
//   A behavioural model per instance predicts vld/code/pend/any every cycle,
//   and directed scenarios add fixed expectations on the grant sequence.
// ----------------------------------------------------------------------------
module tb_prio_encode_irq;

    localparam int N = 8;
    localparam int W = 3;
    localparam logic [2:0] EDGE_CFG = 3'b101;
    localparam logic [2:0] ROT_CFG  = 3'b110;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic [2:0]   ack;

    logic         vld_o  [3];
    logic [W-1:0] code_o [3];
    logic [N-1:0] pend_o [3];
    logic         any_o  [3];

    // Reference model state, one slot per instance
    logic [N-1:0] m_pend [3];
    logic [N-1:0] m_reqd [3];
    int           m_last [3];
    logic         m_vld  [3];
    int           m_code [3];
    logic         m_any  [3];

    int assert_count;
    int fail_count;
    int watch;
    int grant_log[$];

    prio_encode_irq #(.N(N), .W(W), .EDGE(1), .ROTATE(0)) u_e1r0 (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack[0]),
        .vld(vld_o[0]), .code(code_o[0]), .pend(pend_o[0]), .any(any_o[0])
    );

    prio_encode_irq #(.N(N), .W(W), .EDGE(0), .ROTATE(1)) u_e0r1 (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack[1]),
        .vld(vld_o[1]), .code(code_o[1]), .pend(pend_o[1]), .any(any_o[1])
    );

    prio_encode_irq #(.N(N), .W(W), .EDGE(1), .ROTATE(1)) u_e1r1 (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack[2]),
        .vld(vld_o[2]), .code(code_o[2]), .pend(pend_o[2]), .any(any_o[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock of the model: pending bits follow the capture rule, the
    // grant is picked by scanning indices in priority order.
    task automatic modelStep(input int k);
        logic [N-1:0] elig;
        logic [N-1:0] next_pend;
        logic         accepted;
        int           pick;
        int           idx;
        if (!rst_n) begin
            m_pend[k] = '0;
            m_reqd[k] = '0;
            m_last[k] = N - 1;
            m_vld[k]  = 1'b0;
            m_code[k] = 0;
            m_any[k]  = 1'b0;
        end else begin
            elig     = m_pend[k] & ~mask;
            accepted = m_vld[k] && ack[k];
            for (int i = 0; i < N; i++) begin
                if (EDGE_CFG[k])
                    next_pend[i] = (m_pend[k][i] && !(accepted && m_code[k] == i))
                                   || (req[i] && !m_reqd[k][i]);
                else
                    next_pend[i] = req[i];
            end
            m_any[k] = (elig != '0);
            if (!m_vld[k]) begin
                pick = -1;
                for (int j = 0; j < N; j++) begin
                    idx = ROT_CFG[k] ? (m_last[k] + 1 + j) % N : j;
                    if (pick < 0 && elig[idx]) pick = idx;
                end
                if (pick >= 0) begin
                    m_code[k] = pick;
                    m_vld[k]  = 1'b1;
                end
            end else if (accepted) begin
                m_vld[k]  = 1'b0;
                m_last[k] = m_code[k];
            end
            m_pend[k] = next_pend;
            m_reqd[k] = req;
        end
    endtask

    function automatic logic [2:0] autoAck();
        return {m_vld[2], m_vld[1], m_vld[0]};
    endfunction

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] m,
                                 input logic rn, input logic [2:0] a);
        req   = r;
        mask  = m;
        rst_n = rn;
        ack   = a;
    endtask

    // Log accepted grants of the watched instance, advance one clock, then
    // compare every instance against the model on the falling edge.
    task automatic runCycle();
        if (rst_n && ack[watch] && vld_o[watch] === 1'b1)
            grant_log.push_back(int'(code_o[watch]));
        @(posedge clk);
        for (int k = 0; k < 3; k++) modelStep(k);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("vld%0d", k),  vld_o[k],  m_vld[k]);
            checkOutput($sformatf("code%0d", k), code_o[k], m_code[k]);
            checkOutput($sformatf("pend%0d", k), pend_o[k], m_pend[k]);
            checkOutput($sformatf("any%0d", k),  any_o[k],  m_any[k]);
        end
    endtask

    task automatic doReset();
        applyStimulus('0, '0, 1'b0, 3'b000);
        runCycle();
        runCycle();
        grant_log.delete();
    endtask

    function automatic int logAt(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] m;
        logic [2:0]   a;
        logic         rn;
        assert_count = 0;
        fail_count   = 0;
        watch        = 0;
        applyStimulus('0, '0, 1'b0, 3'b000);

        $display("[TB] reset and idle");
        doReset();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(8'h00, 8'h00, 1'b1, 3'b000);
            runCycle();
        end
        checkOutput("s1_vld",  vld_o[0],  1'b0);
        checkOutput("s1_code", code_o[0], 3'd0);
        checkOutput("s1_pend", pend_o[0], 8'h00);
        checkOutput("s1_any",  any_o[0],  1'b0);

        $display("[TB] edge capture, fixed priority");
        watch = 0;
        doReset();
        applyStimulus(8'h24, 8'h00, 1'b1, autoAck());
        runCycle();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(8'h00, 8'h00, 1'b1, autoAck());
            runCycle();
        end
        checkOutput("s2_count", grant_log.size(), 2);
        checkOutput("s2_first", logAt(0), 2);
        checkOutput("s2_second", logAt(1), 5);
        checkOutput("s2_pend", pend_o[0], 8'h00);
        checkOutput("s2_vld", vld_o[0], 1'b0);

        $display("[TB] level capture, rotating priority");
        watch = 1;
        doReset();
        for (int c = 0; c < 12; c++) begin
            applyStimulus(8'h81, 8'h00, 1'b1, autoAck());
            runCycle();
        end
        checkOutput("s3_g0", logAt(0), 0);
        checkOutput("s3_g1", logAt(1), 7);
        checkOutput("s3_g2", logAt(2), 0);
        checkOutput("s3_g3", logAt(3), 7);

        $display("[TB] masking");
        watch = 0;
        doReset();
        applyStimulus(8'h09, 8'h01, 1'b1, autoAck());
        runCycle();
        for (int c = 0; c < 7; c++) begin
            applyStimulus(8'h00, 8'h01, 1'b1, autoAck());
            runCycle();
        end
        checkOutput("s4_masked_count", grant_log.size(), 1);
        checkOutput("s4_masked_code", logAt(0), 3);
        checkOutput("s4_latched", pend_o[0], 8'h01);
        checkOutput("s4_any_masked", any_o[0], 1'b0);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(8'h00, 8'h00, 1'b1, autoAck());
            runCycle();
        end
        checkOutput("s4_count", grant_log.size(), 2);
        checkOutput("s4_unmasked_code", logAt(1), 0);

        $display("[TB] new edge together with ack");
        doReset();
        applyStimulus(8'h10, 8'h00, 1'b1, 3'b000);
        runCycle();
        applyStimulus(8'h00, 8'h00, 1'b1, 3'b000);
        runCycle();
        checkOutput("s5_vld_a", vld_o[0], 1'b1);
        checkOutput("s5_code_a", code_o[0], 3'd4);
        applyStimulus(8'h10, 8'h00, 1'b1, 3'b001);
        runCycle();
        checkOutput("s5_pend_kept", pend_o[0][4], 1'b1);
        checkOutput("s5_vld_drop", vld_o[0], 1'b0);
        applyStimulus(8'h10, 8'h00, 1'b1, 3'b000);
        runCycle();
        checkOutput("s5_vld_b", vld_o[0], 1'b1);
        checkOutput("s5_code_b", code_o[0], 3'd4);
        applyStimulus(8'h00, 8'h00, 1'b1, 3'b001);
        runCycle();
        checkOutput("s5_pend_clear", pend_o[0], 8'h00);

        $display("[TB] reset with ack while presenting");
        doReset();
        applyStimulus(8'h10, 8'h00, 1'b1, 3'b000);
        runCycle();
        applyStimulus(8'h00, 8'h00, 1'b1, 3'b000);
        runCycle();
        checkOutput("s6_present", vld_o[0], 1'b1);
        applyStimulus(8'h40, 8'h00, 1'b0, 3'b111);
        runCycle();
        checkOutput("s6_vld",  vld_o[0],  1'b0);
        checkOutput("s6_code", code_o[0], 3'd0);
        checkOutput("s6_pend", pend_o[0], 8'h00);
        checkOutput("s6_any",  any_o[0],  1'b0);
        grant_log.delete();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(8'h40, 8'h00, 1'b1, autoAck());
            runCycle();
        end
        checkOutput("s6_count", grant_log.size(), 1);
        checkOutput("s6_code_after", logAt(0), 6);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            r  = 8'($urandom) & 8'($urandom);
            m  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            a  = ($urandom_range(0, 1) == 0) ? autoAck() : 3'($urandom);
            rn = ($urandom_range(0, 60) != 0);
            applyStimulus(r, m, rn, a);
            runCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
